// File: rtl/mux16_sched_pkg.sv
// Shared constants and types for the 16-way round-robin mux scheduler.
package mux16_sched_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {IDLE, SERVE} sched_state_t;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux16_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, wrapping at 15.
module mux16_rr_pick
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  output logic             any,
  output sel_t             winner
);

  logic [N_REQ-1:0] rot;
  sel_t             off;
  logic             found;

  // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit is the winner's offset.
  always_comb begin
    rot   = N_REQ'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  assign any    = |req;
  assign winner = ptr + off;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler owning the select of a shared 16:1 one-bit mux, with bounded bursts per grant.
// Optional input `lock` (suspends the burst limit) is compiled in with MUX16_SCHED_LOCK_EN.
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             out_ready,
`ifdef MUX16_SCHED_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             out_valid,
  output logic             out_data,
  output logic             busy
);

  localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

  sched_state_t     state_q, state_d;
  sel_t             sel_q, sel_d;
  sel_t             ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [3:0]       cnt_q, cnt_d;

  logic any;
  sel_t winner;
  logic serving;
  logic xfer;
  logic hold_done;

  mux16_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .winner (winner)
  );

  assign serving = (state_q == SERVE);
  assign xfer    = serving && out_ready;

  // cnt saturates, so >= keeps the limit meaningful after a long locked burst.
`ifdef MUX16_SCHED_LOCK_EN
  assign hold_done = (cnt_q >= CNT_LAST) && !lock;
`else
  assign hold_done = (cnt_q >= CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = SERVE;
          sel_d   = winner;
          grant_d = N_REQ'(1) << winner;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        if (!req[sel_q] || (xfer && hold_done)) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q + sel_t'(1);
          cnt_d   = '0;
        end else if (xfer && (cnt_q != '1)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign out_valid = serving;
  assign busy      = serving;
  assign out_data  = serving & data_in[sel_q];

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus random traffic against a behavioural model.
module tb_mux16_rr_sched;
  import mux16_sched_pkg::*;

  localparam int HOLD = 4;
`ifdef MUX16_SCHED_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, out_ready, lock_v;
  logic [15:0] req, data_in;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid, out_data, busy;

  always #5 clk = ~clk;

  mux16_rr_sched #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
`ifdef MUX16_SCHED_LOCK_EN
    .lock      (lock_v),
`endif
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Behavioural model: who is being served, where the rotation resumes, accepted beats so far.
  bit m_busy;
  int m_sel, m_ptr, m_cnt;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic r, input logic [15:0] rq, input logic rdy, input logic lk);
    bit exit_now;
    if (r) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 0; k < 16; k++) begin
        if (!m_busy && rq[(m_ptr + k) % 16]) begin
          m_busy = 1'b1;
          m_sel  = (m_ptr + k) % 16;
          m_cnt  = 0;
        end
      end
    end else begin
      exit_now = !rq[m_sel] || (rdy && (m_cnt >= HOLD - 1) && !(LOCK_EN && lk));
      if (exit_now) begin
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % 16;
        m_cnt  = 0;
      end else if (rdy) begin
        m_cnt++;
      end
    end
  endtask

  // One clock: drive inputs just after the edge, compare outputs against the model, then advance the model.
  task automatic cycle(input logic r, input logic [15:0] rq, input logic [15:0] d,
                       input logic rdy, input logic lk);
    logic [15:0] exp_grant;
    @(posedge clk);
    #1;
    rst = r; req = rq; data_in = d; out_ready = rdy; lock_v = lk;
    #1;
    exp_grant = m_busy ? (16'(1) << m_sel) : 16'h0000;
    chk("sel", 32'(sel), 32'(m_sel));
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("out_valid", 32'(out_valid), 32'(m_busy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("out_data", 32'(out_data), 32'(m_busy ? d[m_sel] : 1'b0));
    model_step(r, rq, rdy, lk);
  endtask

  initial begin
    logic [15:0] rq_r;
    int          last_sel, run_len;
    bit          prev_busy;

    rst = 1'b1; req = '0; data_in = '0; out_ready = 1'b0; lock_v = 1'b0;
    model_reset();
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(1, 16'h0000, 16'h0000, 0, 0);

    // Single requester 0: grant one cycle after req, four beats, then ptr=1.
    cycle(0, 16'h0001, 16'($urandom) | 16'h0001, 1, 0);
    cycle(0, 16'h0001, 16'($urandom) | 16'h0001, 1, 0);
    chk("t1_grant", 32'(grant), 32'h0001);
    chk("t1_sel", 32'(sel), 32'h0);
    chk("t1_data", 32'(out_data), 32'h1);
    repeat (3) cycle(0, 16'h0001, 16'($urandom), 1, 0);
    // ptr=1 now, so requester 15 beats requester 0.
    cycle(0, 16'h8001, 16'($urandom), 1, 0);
    chk("t2_bubble", 32'(busy), 32'h0);
    cycle(0, 16'h8001, 16'($urandom), 1, 0);
    chk("t2_sel15", 32'(sel), 32'hF);
    chk("t2_grant15", 32'(grant), 32'h8000);
    repeat (3) cycle(0, 16'h8001, 16'($urandom), 1, 0);
    cycle(0, 16'h8001, 16'($urandom), 1, 0);
    chk("t2_bubble2", 32'(out_valid), 32'h0);
    cycle(0, 16'h8001, 16'($urandom), 1, 0);
    chk("t2_wrap_sel0", 32'(grant), 32'h0001);

    // All requesting: strict rotation, four valid cycles per grant.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    prev_busy = 1'b0; last_sel = 15; run_len = 0;
    repeat (90) begin
      cycle(0, 16'hFFFF, 16'($urandom), 1, 0);
      if (busy && !prev_busy) begin
        chk("rot_order", 32'(sel), 32'((last_sel + 1) % 16));
        last_sel = int'(sel);
        run_len  = 0;
      end
      if (busy) run_len++;
      if (!busy && prev_busy) chk("rot_len", 32'(run_len), 32'(HOLD));
      prev_busy = busy;
    end

    // Backpressure on requester 5, then abandon with out_ready low.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h0020, 16'($urandom), 0, 0);
    repeat (10) cycle(0, 16'h0020, 16'($urandom), 0, 0);
    chk("t4_hold_busy", 32'(busy), 32'h1);
    chk("t4_hold_sel", 32'(sel), 32'h5);
    cycle(0, 16'h0000, 16'($urandom), 0, 0);
    cycle(0, 16'h0060, 16'($urandom), 0, 0);
    chk("t4_abandon", 32'(busy), 32'h0);
    cycle(0, 16'h0060, 16'($urandom), 0, 0);
    chk("t4_ptr6", 32'(sel), 32'h6);

    // Reset mid-burst at cnt=2.
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    cycle(0, 16'h0001, 16'($urandom), 1, 0);
    cycle(0, 16'h0001, 16'($urandom), 1, 0);
    cycle(0, 16'h0001, 16'($urandom), 1, 0);
    cycle(1, 16'h0001, 16'hFFFF, 1, 0);
    cycle(0, 16'h0006, 16'hFFFF, 1, 0);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_sel", 32'(sel), 32'h0);
    chk("t5_rst_data", 32'(out_data), 32'h0);
    cycle(0, 16'h0006, 16'($urandom), 1, 0);
    chk("t5_regrant", 32'(sel), 32'h1);

`ifdef MUX16_SCHED_LOCK_EN
    cycle(1, 16'h0000, 16'h0000, 0, 0);
    repeat (9) cycle(0, 16'h0008, 16'($urandom), 1, 1);
    chk("t6_lock_busy", 32'(busy), 32'h1);
    chk("t6_lock_sel", 32'(sel), 32'h3);
    cycle(0, 16'h0008, 16'($urandom), 1, 0);
    cycle(0, 16'h0008, 16'($urandom), 1, 0);
    chk("t6_unlock_exit", 32'(busy), 32'h0);
`endif

    // Random traffic with occasional resets and bursty request changes.
    rq_r = 16'($urandom);
    repeat (400) begin
      if ($urandom_range(3) == 0) rq_r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      cycle(($urandom_range(49) == 0), rq_r, 16'($urandom),
            ($urandom_range(3) != 0), ($urandom_range(2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux16_rr_sched.md
Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares a single 16:1 one-bit multiplexer path between 16 requesters. It arbitrates among asserted requests and drives the 4-bit mux select. It holds each grant for a bounded burst of transfers and presents the selected input bit on a valid/ready output port. It sits directly in front of the 16:1 mux and owns its select lines.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16, exposed for package consistency only.
- SEL_W, 4, select width (log2 N_REQ).
- HOLD_MAX, 4, maximum accepted transfers per grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  16  request per input; bit i pairs with data_in[i].
- data_in  in  16  one data bit per requester (mux inputs E0..E15).
- out_ready  in  1  downstream accepts out_data this cycle.
- sel  out  4  registered mux select; index of the granted requester.
- grant  out  16  registered one-hot grant; all-zero when not serving.
- out_valid  out  1  high in SERVE.
- out_data  out  1  data_in[sel] when out_valid, else 0 (combinational from sel).
- busy  out  1  high in SERVE.

Behaviour:
- Reset: synchronous on rst=1 at a clk edge, from any state (including mid-burst).
  - Values: state=IDLE, sel=0, grant=0, out_valid=0, out_data=0, busy=0, rr pointer ptr=0, beat counter cnt=0.
  - Nothing in flight is preserved.
- States:
  - IDLE
    - If req==0, stay in IDLE.
    - Otherwise the winner is the first set req bit scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16 wrap).
    - On the next edge: sel=winner, grant=1<<winner, cnt=0, state=SERVE.
    - Latency: req seen in cycle t gives grant/out_valid in cycle t+1.
  - SERVE
    - A transfer is out_valid && out_ready in the same cycle; each transfer increments cnt.
    - Exit to IDLE on the edge where either:
      - a transfer occurs and (cnt==HOLD_MAX-1 or req[sel]==0); or
      - req[sel]==0 with no transfer (abandon).
    - On exit: grant=0, ptr=(sel+1) mod 16 with 15 wrapping to 0, cnt=0.
    - sel keeps its last value in IDLE.
- Bubble: every exit passes through at least one IDLE cycle (out_valid=0) before the next grant. The same requester may win again only if no other requester sits earlier in rotation order.
- In SERVE, changes to other req bits are ignored. data_in[sel] may change cycle to cycle; out_data follows it combinationally.
- Simultaneous requests: round-robin only, with no fixed priority beyond the scan from ptr.
- Backpressure: with out_ready=0, the grant is held indefinitely while req[sel]=1. The HOLD_MAX limit counts accepted transfers only.
- Invariants: grant is one-hot or zero; grant==(1<<sel) whenever busy=1.

Optional Feature:
- Macro: MUX16_SCHED_LOCK_EN.
- With the macro: adds input lock (1 bit, placed after out_ready). While lock=1 in SERVE, the HOLD_MAX exit condition is suppressed; the req[sel]==0 exits still apply. The transfer in which lock falls with cnt≥HOLD_MAX-1 exits normally.
- Without the macro: the port is absent and HOLD_MAX is always enforced.

Decomposition:
- Package mux16_sched_pkg:
  - N_REQ and SEL_W constants.
  - typedef enum logic {IDLE, SERVE} sched_state_t.
  - typedef logic [SEL_W-1:0] sel_t.
- Sub-module mux16_rr_pick: purely combinational rotate-and-priority-encode. Inputs req[15:0] and ptr[3:0]; outputs any (1 bit) and winner[3:0].
- The top module holds the FSM, ptr, cnt, sel/grant registers and the output mux.

Test Plan:
- Reset, then req=16'h0001, data_in[0]=1, out_ready=1 → one cycle later sel=0, grant=16'h0001, out_valid=1, out_data=1. Exit after 4 transfers; ptr=1.
- req=16'h8001, ptr=1 → grant to 15 (sel=4'hF) first. After its burst, ptr wraps to 0 and the next grant goes to 0 after one IDLE bubble.
- req=16'hFFFF held, out_ready=1 → grants rotate 0,1,…,15,0. Each lasts exactly 4 out_valid cycles, separated by one idle cycle.
- Grant to 5, out_ready=0 for 10 cycles → sel=5 held, cnt=0 and no exit. Then drop req[5] with out_ready=0 → IDLE next edge, ptr=6.
- rst=1 during SERVE at cnt=2 → next edge: all outputs 0, ptr=0. Re-requests with req=16'h0006 grant index 1.
- Macro defined, lock=1, req[3] held → more than 4 transfers granted to 3. Lowering lock at cnt≥3 → exit on that transfer.
